// File: rtl/matrix_animator.sv
// matrix_animator: Wishbone pipelined master that renders one 8-row animation
// frame per frame tick into the LED matrix driver's row registers.
module matrix_animator #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 3,
    parameter int FRAME_DIV     = 4194304,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enable,
    input  logic                       i_mode,
    output logic                       o_wb_cyc,
    output logic                       o_wb_stb,
    output logic                       o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [WB_DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0]   o_wb_wdata,
    input  logic                       i_wb_ack,
    input  logic                       i_wb_stall,
    output logic                       o_frame_done,
    output logic                       o_err,
    output logic [7:0]                 o_frame
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;
    localparam int CW = $clog2(FRAME_DIV);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]               state_q, state_d;
    logic [2:0]               row_q, row_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TW-1:0]            tmr_q, tmr_d;
    logic [7:0]               frame_q, frame_d;
    logic [WB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic tick_q, tick_d, pend_q, pend_d, mode_q, mode_d;
    logic cyc_q, cyc_d, stb_q, stb_d, done_q, done_d, err_q, err_d;
    logic start, acked, wrap;

    // Column 0 lands in the most significant nibble.
    function automatic logic [WB_DATA_WIDTH-1:0] render(input logic [2:0] r, input logic m,
                                                        input logic [7:0] f);
        logic [WB_DATA_WIDTH-1:0] w;
        w = '0;
        for (int c = 0; c < 8; c++)
            w[WB_DATA_WIDTH-1-4*c -: 4] = m ? (({r, 3'(c)} == f[5:0]) ? 4'h7 : 4'h0)
                                            : {1'b0, r + 3'(c) + f[2:0]};
        return w;
    endfunction

    assign wrap   = cnt_q == CW'(FRAME_DIV - 1);
    assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    assign tick_d = wrap && i_enable;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mode_d  = mode_q;
        frame_d = frame_q;
        pend_d  = pend_q | (tick_q && state_q != S_IDLE);
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;
        acked   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                start   = tick_q || pend_q;
                state_d = S_IDLE;
            end
            S_REQ: if (!i_wb_stall) begin
                state_d = S_WAIT;
                tmr_d   = '0;
                acked   = i_wb_ack;
            end
            S_WAIT: begin
                acked = i_wb_ack;
                tmr_d = tmr_q + 1'b1;
                if (!i_wb_ack && tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acked) begin
            state_d = (row_q == 3'd7) ? S_DONE : S_REQ;
            row_d   = row_q + 3'd1;
            done_d  = row_q == 3'd7;
            frame_d = frame_q + {7'd0, row_q == 3'd7};
        end
        if (start) begin
            state_d = S_REQ;
            row_d   = '0;
            mode_d  = i_mode;
            pend_d  = 1'b0;
        end
        cyc_d   = state_d == S_REQ || state_d == S_WAIT;
        stb_d   = state_d == S_REQ;
        wdata_d = stb_d ? render(row_d, mode_d, frame_d) : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            frame_q <= '0;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
            mode_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            frame_q <= frame_d;
            wdata_q <= wdata_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = 1'b1;
    assign o_wb_addr    = WB_ADDR_WIDTH'(row_q);
    assign o_wb_sel     = '1;
    assign o_wb_wdata   = wdata_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;
    assign o_frame      = frame_q;
endmodule
